// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared constants for the mux_rr_arb channel multiplexer.
//  Revision    : 1.0  initial release
// ============================================================================
package mux_pkg;

   // Selection mode encodings for the mode input
   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

endpackage : mux_pkg
`default_nettype wire

// File: rtl/rr_grant.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant
//  Description : Combinational round-robin grant. Scans requests starting at
//                ptr, wraps past NCH-1 to 0, and returns a one-hot grant
//                together with the binary index of the granted channel.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_grant #(
   parameter int NCH  = 4,
   parameter int SELW = $clog2(NCH)
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] ptr,
   output logic [NCH-1:0]  grant,
   output logic [SELW-1:0] idx
);

   logic w_found;

   // Two passes: first the channels at or above ptr, then the wrapped-around
   // channels below ptr. The first request hit in scan order wins.
   always_comb begin
      grant   = '0;
      idx     = '0;
      w_found = 1'b0;
      for (int n = 0; n < NCH; n++) begin
         if (!w_found && req[n] && (SELW'(n) >= ptr)) begin
            w_found  = 1'b1;
            grant[n] = 1'b1;
            idx      = SELW'(n);
         end
      end
      // Any channel still requesting here lies below ptr (wrap region)
      for (int n = 0; n < NCH; n++) begin
         if (!w_found && req[n]) begin
            w_found  = 1'b1;
            grant[n] = 1'b1;
            idx      = SELW'(n);
         end
      end
   end

endmodule : rr_grant
`default_nettype wire

// File: rtl/mux_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mux_rr_arb
//  Description : N-channel, W-bit multiplexer with a single-entry registered
//                output and valid/ready handshakes. Channel choice is either a
//                fixed select (mode 0) or round-robin arbitration (mode 1).
//  Revision    : 1.0  initial release
// ============================================================================
module mux_rr_arb
   import mux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NCH   = 4,
   parameter int SELW  = $clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_ch,
   output logic                 out_valid,
   input  logic                 out_ready
);

   // Registered state
   logic [WIDTH-1:0] r_out_data;
   logic [SELW-1:0]  r_out_ch;
   logic             r_out_valid;
   logic [SELW-1:0]  r_ptr;

   // Combinational grant path
   logic [WIDTH-1:0] w_ch_data [NCH];
   logic [NCH-1:0]   w_fix_grant;
   logic [NCH-1:0]   w_rr_grant;
   logic [SELW-1:0]  w_rr_idx;
   logic [NCH-1:0]   w_grant;
   logic [SELW-1:0]  w_gidx;
   logic [WIDTH-1:0] w_sel_data;
   logic             w_load_en;
   logic             w_xfer;
   logic [SELW-1:0]  w_ptr_next;

   // Unpack the flat input bus into one word per channel
   generate
      for (genvar g = 0; g < NCH; g++) begin : g_ch
         assign w_ch_data[g] = in_data[g*WIDTH +: WIDTH];
      end
   endgenerate

   // Round-robin arbiter; its result is only consulted in round-robin mode
   rr_grant #(
      .NCH  (NCH),
      .SELW (SELW)
   ) u_rr_grant (
      .req   (in_valid),
      .ptr   (r_ptr),
      .grant (w_rr_grant),
      .idx   (w_rr_idx)
   );

   // Fixed-select decode: an out-of-range sel matches no channel, so no grant
   always_comb begin
      w_fix_grant = '0;
      for (int n = 0; n < NCH; n++) begin
         if (SELW'(n) == sel) begin
            w_fix_grant[n] = in_valid[n];
         end
      end
   end

   // Pick grant and index according to the current mode
   always_comb begin
      w_grant = w_fix_grant;
      w_gidx  = sel;
      if (mode == MODE_RR) begin
         w_grant = w_rr_grant;
         w_gidx  = w_rr_idx;
      end
   end

   // Data select driven by the one-hot grant, so an empty grant yields zero
   always_comb begin
      w_sel_data = '0;
      for (int n = 0; n < NCH; n++) begin
         if (w_grant[n]) begin
            w_sel_data = w_ch_data[n];
         end
      end
   end

   // Register may accept a word when empty or being drained this cycle.
   // rst_n gates in_ready so no producer sees acceptance while in reset.
   assign w_load_en = !r_out_valid || out_ready;
   assign in_ready  = (rst_n && w_load_en) ? w_grant : '0;
   assign w_xfer    = |in_ready;

   // Pointer advances to the channel after the winner, wrapping at NCH-1
   assign w_ptr_next = (w_gidx == SELW'(NCH-1)) ? '0 : w_gidx + 1'b1;

   // Output register: load on input transfer, otherwise empty on drain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_out_valid <= 1'b0;
      end else if (w_xfer) begin
         r_out_data  <= w_sel_data;
         r_out_ch    <= w_gidx;
         r_out_valid <= 1'b1;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // Round-robin pointer: moves only on a round-robin input transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (w_xfer && (mode == MODE_RR)) begin
         r_ptr <= w_ptr_next;
      end
   end

   assign out_data  = r_out_data;
   assign out_ch    = r_out_ch;
   assign out_valid = r_out_valid;

endmodule : mux_rr_arb
`default_nettype wire

// File: tb/tb_mux_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_rr_arb
//  Description : Directed self-checking bench for mux_rr_arb (WIDTH=8, NCH=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mux_rr_arb;

   localparam int WIDTH = 8;
   localparam int NCH   = 4;
   localparam int SELW  = 2;

   logic                 clk;
   logic                 rst_n;
   logic [NCH*WIDTH-1:0] in_data;
   logic [NCH-1:0]       in_valid;
   logic [NCH-1:0]       in_ready;
   logic                 mode;
   logic [SELW-1:0]      sel;
   logic [WIDTH-1:0]     out_data;
   logic [SELW-1:0]      out_ch;
   logic                 out_valid;
   logic                 out_ready;

   int errors = 0;
   int checks = 0;

   mux_rr_arb #(
      .WIDTH (WIDTH),
      .NCH   (NCH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .sel       (sel),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle 1 ns past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int idx, input logic [WIDTH-1:0] val);
      in_data[idx*WIDTH +: WIDTH] = val;
   endtask

   initial begin
      rst_n     = 1'b0;
      mode      = 1'b1;
      sel       = '0;
      out_ready = 1'b1;
      in_valid  = 4'hF;
      for (int i = 0; i < NCH; i++) set_ch(i, 8'(8'h10 + i));

      // Reset with all channels requesting
      #3;
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_data",  32'(out_data),  32'h0);
      chk("rst_ch",    32'(out_ch),    32'h0);
      chk("rst_ready", 32'(in_ready),  32'h0);
      tick();
      tick();
      chk("rst_valid_clk", 32'(out_valid), 32'h0);
      chk("rst_ready_clk", 32'(in_ready),  32'h0);

      // Release: round-robin starts at channel 0
      rst_n = 1'b1;
      #1;
      chk("rel_ready", 32'(in_ready), 32'h1);

      // Fairness: all valid, grants 0,1,2,3,0
      tick();
      chk("rr0_ch",   32'(out_ch),    32'h0);
      chk("rr0_data", 32'(out_data),  32'h10);
      chk("rr0_vld",  32'(out_valid), 32'h1);
      tick();
      chk("rr1_ch",   32'(out_ch),   32'h1);
      chk("rr1_data", 32'(out_data), 32'h11);
      tick();
      chk("rr2_ch",   32'(out_ch),   32'h2);
      tick();
      chk("rr3_ch",   32'(out_ch),   32'h3);
      chk("rr3_data", 32'(out_data), 32'h13);
      tick();
      chk("rr4_ch",   32'(out_ch),   32'h0);
      // ptr now 1; single ch1 transfer moves it to 2
      in_valid = 4'b0010;
      #1;
      chk("only1_ready", 32'(in_ready), 32'h2);
      tick();
      chk("only1_ch", 32'(out_ch), 32'h1);

      // Skip/wrap with ptr = 2: only ch1 and ch3 -> 3,1,3,1
      in_valid = 4'b1010;
      #1;
      chk("sw_ready0", 32'(in_ready), 32'h8);
      tick();
      chk("sw0_ch", 32'(out_ch), 32'h3);
      chk("sw_ready1", 32'(in_ready), 32'h2);
      tick();
      chk("sw1_ch", 32'(out_ch), 32'h1);
      tick();
      chk("sw2_ch", 32'(out_ch), 32'h3);
      tick();
      chk("sw3_ch", 32'(out_ch), 32'h1);
      // ptr is now 2

      // Fixed mode: sel = 2, ch2 = A5
      mode     = 1'b0;
      sel      = 2'd2;
      in_valid = 4'hF;
      set_ch(2, 8'hA5);
      #1;
      chk("fix_ready", 32'(in_ready), 32'h4);
      tick();
      chk("fix_data", 32'(out_data), 32'hA5);
      chk("fix_ch",   32'(out_ch),   32'h2);
      for (int i = 0; i < 3; i++) begin
         chk("fix_ready_hold", 32'(in_ready), 32'h4);
         tick();
      end
      // Fixed select with sel channel idle grants nothing
      in_valid = 4'b1011;
      #1;
      chk("fix_idle_ready", 32'(in_ready), 32'h0);
      tick();
      chk("fix_idle_drain", 32'(out_valid), 32'h0);
      chk("fix_idle_hold",  32'(out_data),  32'hA5);

      // Back-pressure: 3C held for 3 cycles, then drain+load together
      sel      = 2'd1;
      in_valid = 4'hF;
      set_ch(1, 8'h3C);
      tick();
      chk("bp_load", 32'(out_data), 32'h3C);
      out_ready = 1'b0;
      set_ch(1, 8'h5A);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_ready", 32'(in_ready),  32'h0);
         tick();
         chk("bp_data",  32'(out_data),  32'h3C);
         chk("bp_ch",    32'(out_ch),    32'h1);
         chk("bp_vld",   32'(out_valid), 32'h1);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(in_ready), 32'h2);
      tick();
      chk("bp_next_data", 32'(out_data),  32'h5A);
      chk("bp_next_vld",  32'(out_valid), 32'h1);
      in_valid = 4'h0;
      tick();
      chk("drain_vld",  32'(out_valid), 32'h0);
      chk("drain_hold", 32'(out_data),  32'h5A);

      // Back to round-robin: ptr must still be 2 after fixed-mode traffic
      mode     = 1'b1;
      in_valid = 4'hF;
      #1;
      chk("ptr_kept_ready", 32'(in_ready), 32'h4);
      tick();
      chk("ptr_kept_ch", 32'(out_ch), 32'h2);
      chk("ptr_kept_vld", 32'(out_valid), 32'h1);

      // Asynchronous reset between edges
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_vld",   32'(out_valid), 32'h0);
      chk("arst_data",  32'(out_data),  32'h0);
      chk("arst_ch",    32'(out_ch),    32'h0);
      chk("arst_ready", 32'(in_ready),  32'h0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("arst_ptr_ready", 32'(in_ready), 32'h1);
      tick();
      chk("arst_first_ch", 32'(out_ch), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_mux_rr_arb
`default_nettype wire

// File: doc/mux_rr_arb.md
# mux_rr_arb

Parametrised N-channel, W-bit multiplexer with registered output and valid/ready handshakes on every input and on the output. It selects one channel per transfer either by a fixed select input or by round-robin arbitration across requesting channels. It sits between multiple producer channels and a single consumer, replacing bare 2:1 combinational selection wherever back-pressure or fairness is required.

## Interface
- WIDTH, 8, data width per channel (>=1)
- NCH, 4, number of input channels (2..16)
- SELW, $clog2(NCH), width of channel index (derived, not overridden)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NCH  channel i has data
- in_ready  output  NCH  channel i transfer accepted this cycle
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SELW  channel index used when mode = 0
- out_data  output  WIDTH  registered selected data
- out_ch  output  SELW  index of channel that supplied out_data
- out_valid  output  1  output register holds data
- out_ready  input  1  consumer accepts out_data

One clock; reset is asynchronous and active-low.

## Operation
- Single-entry output register; full when out_valid = 1.
- load_en = !out_valid || out_ready (register empty or draining this cycle).
- Grant (combinational, one-hot or zero):
  - mode 0: grant[sel] = in_valid[sel]; sel >= NCH grants nothing.
  - mode 1: first requesting channel found scanning ptr, ptr+1, ... NCH-1, 0, ... ptr-1.
- in_ready[i] = load_en && grant[i]; at most one bit set; in_ready is independent of in_valid of non-granted channels.
- Input transfer (in_valid[i] && in_ready[i]): out_data <= channel i data, out_ch <= i, out_valid <= 1.
- Output transfer with no input transfer: out_valid <= 0; out_data/out_ch hold.
- ptr (SELW bits, round-robin pointer): on input transfer in mode 1, ptr <= granted+1, wrapping NCH-1 -> 0. ptr unchanged in mode 0 and when no transfer.
- Mode/sel changes take effect on the next grant computation; a held output word is never altered or dropped.
- No request: no grant, all in_ready = 0, register drains normally.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_ch = 0, ptr = 0; in_ready = 0 while rst_n = 0.
- Latency: input transfer at edge k -> out_valid/out_data visible after edge k.
- Throughput: one word per cycle when out_ready held 1 (simultaneous drain and load).
- out_valid = 1 && out_ready = 0: out_data, out_ch stable; all in_ready = 0.
- Reset asserted mid-transfer: held word discarded, outputs return to reset values immediately (asynchronous); first grant after release uses ptr = 0.
- in_valid may drop without transfer; no requirement on producer stability (grant recomputed each cycle).

## Structure
- Package mux_pkg: MODE_FIXED = 1'b0, MODE_RR = 1'b1 constants.
- Sub-module rr_grant (parameters NCH, SELW): combinational req + ptr -> one-hot grant and binary index; used only in mode 1.
- Top holds output register, ptr register, fixed-select decode and data select.

## Test plan
- Reset: rst_n = 0 with all in_valid = 1 -> out_valid = 0, out_data = 0, in_ready = 0; release -> mode 1 grants channel 0 first.
- Fixed mode, WIDTH = 8, NCH = 4: sel = 2, in_data ch2 = 8'hA5, out_ready = 1 -> next cycle out_data = 8'hA5, out_ch = 2; ch0/1/3 never get in_ready.
- Round-robin fairness: all four valid, out_ready = 1 -> out_ch sequence 0,1,2,3,0 one per cycle.
- Round-robin skip/wrap: only ch1 and ch3 valid, ptr = 2 -> grants 3,1,3,1.
- Back-pressure: out_ready = 0 for 3 cycles with word 8'h3C held -> out_data stays 8'h3C, in_ready = 0; out_ready = 1 -> drain and load next word same cycle.
- Async reset mid-stream: assert rst_n between edges while out_valid = 1 -> out_valid drops without a clock edge; ptr back to 0.
